// File: rtl/ramwriter_reset_pkg.sv
// Shared types and constants for the RAM-writer reset sequencer.
package ramwriter_reset_pkg;

    typedef enum logic [1:0] {
        StHold,
        StDelay,
        StRun
    } seq_state_e;

    // seq_sts bit positions
    localparam int unsigned StsRwBit    = 0;
    localparam int unsigned StsBusyBit  = 1;
    localparam int unsigned StsAbortBit = 2;
    localparam int unsigned StsSrcBit   = 3;
    localparam int unsigned StsCntLsb   = 8;
    localparam int unsigned StsRemLsb   = 16;

    // 125 MHz system clock
    localparam int unsigned DefCyclesPerMs = 125000;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CYCLES_PER_MS cycles, restartable via clear.
module ms_tick_gen
    import ramwriter_reset_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DefCyclesPerMs
) (
    input  logic clk,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(CYCLES_PER_MS - 1);

    logic [CntW-1:0] cnt_q;

    // Tick suppressed while clear so a restart never fires a stray tick.
    assign tick = (cnt_q == TermCnt) && !clear;

    // Count 0..CYCLES_PER_MS-1, wrapping on the terminal count.
    always_ff @(posedge clk) begin
        if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/ramwriter_reset_sequencer.sv
// Delayed-release reset for the RAM writer: fast assert, release after a ms-granular delay.
// Optional feature: define DELAY_CFG_EN to take the delay from the delay_cfg port at each entry.
module ramwriter_reset_sequencer
    import ramwriter_reset_pkg::*;
#(
    parameter int unsigned CYCLES_PER_MS = DefCyclesPerMs,
    parameter int unsigned DELAY_MS      = 100,
    parameter int unsigned DELAY_W       = 16
) (
    input  logic               clk,
    input  logic               peripheral_reset,
    input  logic               src_aresetn,
    input  logic               sts_clear,
`ifdef DELAY_CFG_EN
    input  logic [DELAY_W-1:0] delay_cfg,
`endif
    output logic               ramwriter_aresetn,
    output logic [31:0]        seq_sts
);

    seq_state_e         state_q, state_d;
    logic               rw_q, rw_d;
    logic               busy_q, busy_d;
    logic               abort_q, abort_d;
    logic               src_q;
    logic [7:0]         cnt_q, cnt_d;
    logic [DELAY_W-1:0] rem_q, rem_d;
    logic [DELAY_W-1:0] delay_ld;
    logic               tick;
    logic               abort_ev;
    logic               rel_ev;
    logic [15:0]        rem16;

`ifdef DELAY_CFG_EN
    assign delay_ld = delay_cfg;
`else
    assign delay_ld = DELAY_W'(DELAY_MS);
`endif

    // Prescaler only runs in DELAY; held at zero elsewhere so each entry starts a fresh ms.
    ms_tick_gen #(
        .CYCLES_PER_MS(CYCLES_PER_MS)
    ) u_ms_tick_gen (
        .clk  (clk),
        .clear(peripheral_reset || (state_q != StDelay)),
        .tick (tick)
    );

    // Next-state, output and status-event decode.
    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        busy_d   = busy_q;
        rem_d    = rem_q;
        abort_ev = 1'b0;
        rel_ev   = 1'b0;
        case (state_q)
            StHold: begin
                rw_d   = 1'b0;
                busy_d = 1'b0;
                if (src_aresetn) begin
                    state_d = StDelay;
                    busy_d  = 1'b1;
                    rem_d   = delay_ld;
                end
            end
            StDelay: begin
                if (!src_aresetn) begin
                    state_d  = StHold;
                    busy_d   = 1'b0;
                    rem_d    = '0;
                    abort_ev = 1'b1;
                end else if ((rem_q == '0) || (tick && (rem_q == DELAY_W'(1)))) begin
                    // Zero delay releases on the first DELAY cycle; otherwise on the last tick.
                    state_d = StRun;
                    rw_d    = 1'b1;
                    busy_d  = 1'b0;
                    rem_d   = '0;
                    rel_ev  = 1'b1;
                end else if (tick) begin
                    rem_d = rem_q - DELAY_W'(1);
                end
            end
            StRun: begin
                if (!src_aresetn) begin
                    state_d = StHold;
                    rw_d    = 1'b0;
                end
            end
            default: begin
                state_d = StHold;
                rw_d    = 1'b0;
                busy_d  = 1'b0;
                rem_d   = '0;
            end
        endcase

        // A new event beats a coincident sts_clear.
        if (abort_ev) begin
            abort_d = 1'b1;
        end else if (sts_clear) begin
            abort_d = 1'b0;
        end else begin
            abort_d = abort_q;
        end

        if (rel_ev) begin
            if (sts_clear) begin
                cnt_d = 8'd1;
            end else if (cnt_q == 8'hFF) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (sts_clear) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (peripheral_reset) begin
            state_q <= StHold;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            src_q   <= 1'b0;
            cnt_q   <= 8'd0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
            src_q   <= src_aresetn;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

    assign rem16             = 16'(rem_q);
    assign ramwriter_aresetn = rw_q;

    // Pack the status word from registered state.
    always_comb begin
        seq_sts                  = '0;
        seq_sts[StsRwBit]        = rw_q;
        seq_sts[StsBusyBit]      = busy_q;
        seq_sts[StsAbortBit]     = abort_q;
        seq_sts[StsSrcBit]       = src_q;
        seq_sts[StsCntLsb +: 8]  = cnt_q;
        seq_sts[StsRemLsb +: 16] = rem16;
    end

endmodule

// File: tb/tb_ramwriter_reset_sequencer.sv
// Bench for ramwriter_reset_sequencer: table of hand-derived checkpoints plus a per-cycle scoreboard.
module tb_ramwriter_reset_sequencer;

    localparam int unsigned Cpm = 4;
    localparam int unsigned Dms = 3;
    localparam int unsigned Dw  = 16;

    logic        clk = 1'b0;
    logic        peripheral_reset;
    logic        src_aresetn;
    logic        sts_clear;
`ifdef DELAY_CFG_EN
    logic [Dw-1:0] delay_cfg;
`endif
    logic        ramwriter_aresetn;
    logic [31:0] seq_sts;

    always #5 clk = ~clk;

    ramwriter_reset_sequencer #(
        .CYCLES_PER_MS(Cpm),
        .DELAY_MS     (Dms),
        .DELAY_W      (Dw)
    ) dut (
        .clk              (clk),
        .peripheral_reset (peripheral_reset),
        .src_aresetn      (src_aresetn),
        .sts_clear        (sts_clear),
`ifdef DELAY_CFG_EN
        .delay_cfg        (delay_cfg),
`endif
        .ramwriter_aresetn(ramwriter_aresetn),
        .seq_sts          (seq_sts)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: tracks edges elapsed since DELAY entry rather than a ms countdown.
    int          m_st  = 0;   // 0 hold, 1 delay, 2 run
    int          m_k   = 0;
    int          m_d   = 0;
    logic        m_rw  = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_abort = 1'b0;
    logic        m_src = 1'b0;
    logic [7:0]  m_cnt = 8'd0;
    logic [15:0] m_rem = 16'd0;

    logic [31:0] sb_q[$];

    typedef struct {
        logic        rst;
        logic        src;
        logic        clr;
        int          n;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic src, input logic clr,
                              input logic [15:0] cfg);
        logic ab_ev;
        logic rel_ev;
        ab_ev  = 1'b0;
        rel_ev = 1'b0;
        if (rst) begin
            m_st = 0; m_k = 0; m_rw = 1'b0; m_busy = 1'b0; m_abort = 1'b0;
            m_src = 1'b0; m_cnt = 8'd0; m_rem = 16'd0;
            return;
        end
        m_src = src;
        case (m_st)
            0: begin
                if (src) begin
                    m_st = 1; m_d = int'(cfg); m_k = 0; m_busy = 1'b1; m_rem = cfg;
                end
            end
            1: begin
                if (!src) begin
                    m_st = 0; m_busy = 1'b0; m_rem = 16'd0; ab_ev = 1'b1;
                end else begin
                    m_k++;
                    if ((m_d == 0 && m_k == 1) || (m_d != 0 && m_k == m_d * int'(Cpm))) begin
                        m_st = 2; m_rw = 1'b1; m_busy = 1'b0; m_rem = 16'd0; rel_ev = 1'b1;
                    end else begin
                        m_rem = 16'(m_d - m_k / int'(Cpm));
                    end
                end
            end
            default: begin
                if (!src) begin
                    m_st = 0; m_rw = 1'b0;
                end
            end
        endcase
        if (ab_ev) m_abort = 1'b1;
        else if (clr) m_abort = 1'b0;
        if (rel_ev) m_cnt = clr ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
        else if (clr) m_cnt = 8'd0;
    endtask

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
    task automatic step(input logic rst, input logic src, input logic clr, input logic [15:0] cfg);
        logic [31:0] exp;
        peripheral_reset = rst;
        src_aresetn      = src;
        sts_clear        = clr;
`ifdef DELAY_CFG_EN
        delay_cfg        = cfg;
`endif
        model_edge(rst, src, clr, cfg);
        sb_q.push_back({m_rem, m_cnt, 4'b0000, m_src, m_abort, m_busy, m_rw});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("sb_seq_sts", seq_sts, exp);
        check("sb_rw_port", {31'd0, ramwriter_aresetn}, {31'd0, exp[0]});
    endtask

    initial begin
        // {rst, src, clr, cycles, seq_sts after the last cycle}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2,  32'h0000_0000}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3,  32'h0000_0000}; // idle in HOLD
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1,  32'h0003_000A}; // entry edge E
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 11, 32'h0001_000A}; // E+11: still busy
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1,  32'h0000_0109}; // E+12: release
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 3,  32'h0000_0109}; // RUN stable
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1,  32'h0000_0100}; // assert in one cycle
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 5,  32'h0002_010A}; // 5 cycles into DELAY
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1,  32'h0000_0104}; // abort
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 12, 32'h0001_010E}; // full restart, E+11
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1,  32'h0000_0109}; // release + clear -> cnt=1
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1,  32'h0000_0009}; // clear in RUN
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1,  32'h0000_0000};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 6,  32'h0002_000A}; // mid-DELAY
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1,  32'h0000_0000}; // reset mid-DELAY
        vecs[15] = '{1'b0, 1'b0, 1'b0, 2,  32'h0000_0000};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 3,  32'h0003_000A};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1,  32'h0000_0004}; // abort + clear -> abort=1
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1,  32'h0000_0000}; // clear abort

        for (int i = 0; i < 19; i++) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                step(vecs[i].rst, vecs[i].src, vecs[i].clr, 16'(Dms));
            end
            check($sformatf("vec%0d_seq_sts", i), seq_sts, vecs[i].exp);
        end

        // Busy window: rises right after entry, falls on the release edge.
        step(1'b0, 1'b1, 1'b0, 16'(Dms));
        check("busy_after_entry", {31'd0, seq_sts[1]}, 32'd1);
        for (int c = 0; c < 11; c++) step(1'b0, 1'b1, 1'b0, 16'(Dms));
        check("rw_low_at_e11", {31'd0, ramwriter_aresetn}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'(Dms));
        check("rw_high_at_e12", {31'd0, ramwriter_aresetn}, 32'd1);
        check("busy_low_at_e12", {31'd0, seq_sts[1]}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 16'(Dms));

`ifdef DELAY_CFG_EN
        // Zero delay: release one cycle after entry.
        step(1'b0, 1'b1, 1'b0, 16'd0);
        check("cfg0_not_yet", {31'd0, ramwriter_aresetn}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        check("cfg0_release", {31'd0, ramwriter_aresetn}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 16'd0);
        // Delay sampled at entry; a later change to 7 is ignored.
        step(1'b0, 1'b1, 1'b0, 16'd2);
        for (int c = 0; c < 7; c++) step(1'b0, 1'b1, 1'b0, 16'd7);
        check("cfg2_not_yet", {31'd0, ramwriter_aresetn}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'd7);
        check("cfg2_release", {31'd0, ramwriter_aresetn}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 16'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
